// File: rtl/tangent_if.sv
`ifndef INPUTOUTBIT
`define INPUTOUTBIT 16
`endif

// Start/done/error handshake between the ALU op sequencer and the tangent unit.
interface tangent_if;
  logic                    start;
  logic [`INPUTOUTBIT-1:0] a;
  logic [`INPUTOUTBIT-1:0] result;
  logic                    error;
  logic                    done;
  logic                    busy;

  modport master (output start, output a, input result, input error, input done, input busy);
  modport slave  (input start, input a, output result, output error, output done, output busy);
endinterface

// File: rtl/tangent.sv
`ifndef INPUTOUTBIT
`define INPUTOUTBIT 16
`endif

// tan(a) for an integer angle in degrees, returned as BF16: range reduction,
// rotation-mode CORDIC for sin/cos, restoring divide, then BF16 packing.
module tangent #(
  parameter int unsigned CORDIC_ITER = 14,
  parameter int unsigned QUOT_BITS   = 24
) (
  input logic      clk,
  input logic      rst,
  tangent_if.slave bus
);

  localparam int unsigned W      = `INPUTOUTBIT;
  localparam int unsigned CntMax = (CORDIC_ITER > QUOT_BITS) ? CORDIC_ITER : QUOT_BITS;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam int unsigned PosW   = $clog2(QUOT_BITS);
  localparam int unsigned DivW   = 18 + QUOT_BITS;

  localparam logic [15:0]        BfNan    = 16'h7FC0;
  localparam logic [15:0]        BfOne    = 16'h3F80;
  localparam logic signed [17:0] KGain    = 18'sd9949;
  localparam logic [17:0]        DegToRad = 18'd286;

  typedef enum logic [3:0] {
    StIdle,
    StReduce,
    StCheck,
    StScale,
    StCordic,
    StDivide,
    StNorm1,
    StNorm2,
    StOutput
  } state_e;

  // atan(2^-i) in Q2.14
  function automatic logic signed [17:0] atan_lut(input logic [CntW-1:0] i);
    logic signed [17:0] v;
    case (int'(i))
      0:       v = 18'sd12868;
      1:       v = 18'sd7596;
      2:       v = 18'sd4014;
      3:       v = 18'sd2037;
      4:       v = 18'sd1023;
      5:       v = 18'sd512;
      6:       v = 18'sd256;
      7:       v = 18'sd128;
      8:       v = 18'sd64;
      9:       v = 18'sd32;
      10:      v = 18'sd16;
      11:      v = 18'sd8;
      12:      v = 18'sd4;
      13:      v = 18'sd2;
      14:      v = 18'sd1;
      default: v = 18'sd0;
    endcase
    return v;
  endfunction

  state_e                state_q, state_d;
  logic signed [10:0]    theta_q, theta_d;
  logic                  illegal_q, illegal_d;
  logic                  sign_q, sign_d;
  logic [6:0]            phi_q, phi_d;
  logic signed [17:0]    x_q, x_d;
  logic signed [17:0]    y_q, y_d;
  logic signed [17:0]    z_q, z_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [17:0]           rem_q, rem_d;
  logic [QUOT_BITS-1:0]  dlo_q, dlo_d;
  logic [PosW-1:0]       lead_q, lead_d;
  logic [15:0]           bf_q, bf_d;
  logic [W-1:0]          result_q, result_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;

  logic signed [W-1:0]   a_s;
  logic                  sgn;
  logic [6:0]            phi;
  logic signed [17:0]    x_sh, y_sh, at;
  logic [17:0]           divisor;
  logic [18:0]           trial;
  logic [16:0]           y_pos;
  logic [DivW-1:0]       dividend;
  logic [PosW-1:0]       lead_enc;
  logic [PosW-1:0]       shamt;
  logic [7:0]            bexp;
  logic [6:0]            mant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      theta_q   <= '0;
      illegal_q <= 1'b0;
      sign_q    <= 1'b0;
      phi_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      dlo_q     <= '0;
      lead_q    <= '0;
      bf_q      <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      theta_q   <= theta_d;
      illegal_q <= illegal_d;
      sign_q    <= sign_d;
      phi_q     <= phi_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dlo_q     <= dlo_d;
      lead_q    <= lead_d;
      bf_q      <= bf_d;
      result_q  <= result_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    theta_d   = theta_q;
    illegal_d = illegal_q;
    sign_d    = sign_q;
    phi_d     = phi_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dlo_d     = dlo_q;
    lead_d    = lead_q;
    bf_d      = bf_q;
    result_d  = result_q;
    error_d   = error_q;
    done_d    = 1'b0;

    a_s      = $signed(bus.a);
    sgn      = theta_q[10];
    phi      = 7'(sgn ? -theta_q : theta_q);
    x_sh     = x_q >>> cnt_q;
    y_sh     = y_q >>> cnt_q;
    at       = atan_lut(cnt_q);
    divisor  = (x_q > 18'sd0) ? $unsigned(x_q) : 18'd1;
    trial    = {rem_q, dlo_q[QUOT_BITS-1]};
    y_pos    = '0;
    dividend = '0;
    lead_enc = '0;
    for (int i = 0; i < QUOT_BITS; i++) begin
      if (dlo_q[i]) lead_enc = PosW'(i);
    end
    shamt = PosW'(QUOT_BITS - 1) - lead_q;
    bexp  = 8'(int'(lead_q) + 127 - 14);
    // Left-justify the quotient so the leading one sits at the MSB; keep the 7 bits below it.
    mant  = 7'((dlo_q << shamt) >> (QUOT_BITS - 8));

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          theta_d   = a_s[10:0];
          illegal_d = (int'(a_s) > 999) || (int'(a_s) < -999);
          error_d   = 1'b0;
          state_d   = StReduce;
        end
      end
      StReduce: begin
        if (illegal_q) begin
          state_d = StCheck;
        end else if (theta_q > 11'sd90) begin
          theta_d = theta_q - 11'sd180;
        end else if (theta_q <= -11'sd90) begin
          theta_d = theta_q + 11'sd180;
        end else begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (illegal_q || phi == 7'd90) begin
          result_d = W'(BfNan);
          error_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (phi == 7'd0) begin
          result_d = '0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (phi == 7'd45) begin
          result_d = W'({sgn, BfOne[14:0]});
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          sign_d  = sgn;
          phi_d   = phi;
          state_d = StScale;
        end
      end
      StScale: begin
        z_d     = $signed(18'(phi_q) * DegToRad);
        x_d     = KGain;
        y_d     = '0;
        cnt_d   = '0;
        state_d = StCordic;
      end
      StCordic: begin
        if (!z_q[17]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - at;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + at;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(CORDIC_ITER - 1)) begin
          // Preload the divider from the final sin so DIVIDE starts on the next edge.
          y_pos    = y_d[17] ? 17'd0 : y_d[16:0];
          dividend = DivW'(y_pos) << 14;
          rem_d    = dividend[DivW-1:QUOT_BITS];
          dlo_d    = dividend[QUOT_BITS-1:0];
          cnt_d    = '0;
          state_d  = StDivide;
        end
      end
      StDivide: begin
        if (trial >= {1'b0, divisor}) begin
          rem_d = 18'(trial - {1'b0, divisor});
          dlo_d = {dlo_q[QUOT_BITS-2:0], 1'b1};
        end else begin
          rem_d = trial[17:0];
          dlo_d = {dlo_q[QUOT_BITS-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(QUOT_BITS - 1)) begin
          cnt_d   = '0;
          state_d = StNorm1;
        end
      end
      StNorm1: begin
        lead_d  = lead_enc;
        state_d = StNorm2;
      end
      StNorm2: begin
        bf_d    = (dlo_q == '0) ? 16'h0000 : {sign_q, bexp, mant};
        state_d = StOutput;
      end
      StOutput: begin
        result_d = W'(bf_q);
        error_d  = 1'b0;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.result = result_q;
  assign bus.error  = error_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_tangent.sv
// Directed and randomized checks of tangent against a degree-domain reference
// model using real-valued tan and modular angle reduction.
module tb_tangent;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  real  pi = 3.14159265358979;

  tangent_if bus ();

  tangent #(
    .CORDIC_ITER(14),
    .QUOT_BITS  (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h..%0h", tag, obs, lo, hi);
    end
  endtask

  // Truncated BF16 magnitude code of a positive real.
  function automatic int bf16_mag(input real v);
    real m = v;
    int  e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return ((127 + e) << 7) | $rtoi((m - 1.0) * 128.0);
  endfunction

  // Reduced angle lies in (-90,90]; r counts the 180-degree steps taken.
  task automatic model(input int ang, output int lat, output logic err, output int sgn,
                       output int phi);
    int t, r;
    if (ang > 999 || ang < -999) begin
      lat = 2; err = 1'b1; sgn = 0; phi = 90;
      return;
    end
    t   = ((ang + 89) % 180 + 180) % 180 - 89;
    r   = (ang - t) / 180;
    if (r < 0) r = -r;
    sgn = (t < 0) ? 1 : 0;
    phi = (t < 0) ? -t : t;
    err = (phi == 90);
    lat = (phi == 90 || phi == 0 || phi == 45) ? r + 2 : r + 44;
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic run_op(input int ang, input int extra_at, input int extra_a,
                        output int lat, output logic [15:0] res, output logic err,
                        output int ndone, output int busy_low, output logic busy_after);
    lat = -1; res = '0; err = 1'b0; ndone = 0; busy_low = 0;
    bus.a     = 16'(ang);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      if (k == extra_at) begin
        bus.a     = 16'(extra_a);
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = k; res = bus.result; err = bus.error; ndone++;
      end else if (!bus.busy) begin
        busy_low++;
      end
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    busy_after = bus.busy;
  endtask

  task automatic verify(input int ang, input int extra_at, input int extra_a, input string tag,
                        output logic [15:0] res);
    int   lat, ndone, busy_low, lat_e, sgn_e, phi_e, tol;
    logic err, err_e, busy_after;
    run_op(ang, extra_at, extra_a, lat, res, err, ndone, busy_low, busy_after);
    model(ang, lat_e, err_e, sgn_e, phi_e);
    check($sformatf("%s_latency", tag), lat, lat_e);
    check($sformatf("%s_error", tag), 32'(err), 32'(err_e));
    check($sformatf("%s_done_count", tag), ndone, 1);
    check($sformatf("%s_busy_low", tag), busy_low, 0);
    check($sformatf("%s_idle_after", tag), 32'(busy_after), 0);
    if (err_e) begin
      check($sformatf("%s_nan", tag), res, 16'h7FC0);
    end else if (phi_e == 0) begin
      check($sformatf("%s_zero", tag), res, 16'h0000);
    end else if (phi_e == 45) begin
      check($sformatf("%s_unit", tag), res, (sgn_e != 0) ? 16'hBF80 : 16'h3F80);
    end else begin
      check($sformatf("%s_sign", tag), 32'(res[15]), sgn_e);
      // Near 0 and 90 degrees the 14-bit sin/cos quantisation dominates the error.
      tol = (phi_e >= 20 && phi_e <= 70) ? 1 : 16;
      check_rng($sformatf("%s_mag", tag), int'(res[14:0]),
                bf16_mag($tan(real'(phi_e) * pi / 180.0)) - tol,
                bf16_mag($tan(real'(phi_e) * pi / 180.0)) + tol);
    end
  endtask

  initial begin
    logic [15:0] res;
    int          ang, mag, ndone;

    rst = 1'b1; bus.start = 1'b0; bus.a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.result, 16'h0000);
    check("reset_error", 32'(bus.error), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    verify(30, 0, 0, "a30", res);
    check_rng("a30_code", res, 16'h3F13, 16'h3F14);
    verify(60, 0, 0, "a60", res);
    check_rng("a60_code", res, 16'h3FDD, 16'h3FDE);
    verify(-120, 0, 0, "am120", res);
    check_rng("am120_code", res, 16'h3FDD, 16'h3FDE);
    verify(999, 0, 0, "a999", res);
    check_rng("a999_code", res, 16'hC0C9, 16'hC0CB);

    verify(0, 0, 0, "a0", res);
    verify(225, 0, 0, "a225", res);
    verify(-45, 0, 0, "am45", res);
    verify(90, 0, 0, "a90", res);
    verify(-90, 0, 0, "am90", res);
    repeat (2) @(posedge clk);
    #1;
    check("hold_error", 32'(bus.error), 1);
    check("hold_result", bus.result, 16'h7FC0);
    verify(1000, 0, 0, "a1000", res);

    // Second start during the divide must be ignored.
    verify(30, 25, 60, "dup", res);
    check_rng("dup_code", res, 16'h3F13, 16'h3F14);

    // Reset while in the CORDIC state.
    bus.a = 16'd30; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_result", bus.result, 16'h0000);
    check("abort_error", 32'(bus.error), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_busy", 32'(bus.busy), 0);
    ndone = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    verify(60, 0, 0, "after_abort", res);
    check_rng("after_abort_code", res, 16'h3FDD, 16'h3FDE);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        mag = int'($urandom_range(1000, 32767));
        ang = ($urandom_range(0, 1) != 0) ? -mag : mag;
      end else begin
        ang = int'($urandom_range(0, 1998)) - 999;
      end
      verify(ang, 0, 0, $sformatf("rnd%0d_a%0d", n, ang), res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
